// File: rtl/dma_reader_len.sv
// dma_reader_len
// Memory-to-stream DMA reader. A config handshake supplies a word-aligned
// start address and a frame length in words. The block reads the frame over
// an AXI3 read port in INCR bursts and emits the words on a valid/ready
// stream, flagging the last word with dout_eof.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cfg_valid/cfg_ready   config handshake; cfg_addr (byte address), cfg_len (words)
//   dout_valid/dout_ready output stream; dout_data word, dout_eof on last word
//   mst_ar*               AXI3 read address channel (id/burst/lock tied off)
//   mst_r*                AXI3 read data channel (rid and rlast are ignored)
//   done                  one-cycle pulse after the frame's last word leaves
//   error                 sticky copy of the most recent non-zero rresp
//
// A burst is only requested once the output fifo has room for all of its
// beats, so rready can stay high for the whole burst and the fifo never
// overflows.
module dma_reader_len #(
  parameter int DataBits  = 64,
  parameter int AddrBits  = 32,
  parameter int LenBits   = 16,
  parameter int BurstSize = 16,
  parameter int FifoDepth = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [AddrBits-1:0] cfg_addr,
  input  logic [LenBits-1:0]  cfg_len,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [DataBits-1:0] dout_data,
  output logic                dout_eof,
  output logic                mst_arvalid,
  input  logic                mst_arready,
  output logic [3:0]          mst_arid,
  output logic [AddrBits-1:0] mst_araddr,
  output logic [3:0]          mst_arlen,
  output logic [2:0]          mst_arsize,
  output logic [1:0]          mst_arburst,
  output logic [1:0]          mst_arlock,
  input  logic                mst_rvalid,
  output logic                mst_rready,
  input  logic [3:0]          mst_rid,
  input  logic [DataBits-1:0] mst_rdata,
  input  logic [1:0]          mst_rresp,
  input  logic                mst_rlast,
  output logic                done,
  output logic [1:0]          error
);

  localparam int Bytes   = DataBits / 8;
  localparam int SizeLog = $clog2(Bytes);
  localparam int U4kBits = $clog2(4096 / Bytes + 1);
  localparam int PtrBits = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntBits = $clog2(FifoDepth + 1);
  localparam int CmpBits = 32;

  typedef enum logic [2:0] {
    Idle,
    Prep1,
    Prep2,
    WaitSpace,
    IssueBurst,
    DoBurst,
    WaitDrain
  } state_t;

  state_t state, state_d;

  logic [AddrBits-1:0] next_addr;
  logic [LenBits-1:0]  remain;
  logic [U4kBits-1:0]  until_4k;
  logic [4:0]          burst;
  logic                zero_frame;

  logic                arvalid_q;
  logic [AddrBits-1:0] araddr_q;
  logic [3:0]          arlen_q;
  logic                done_q;
  logic [1:0]          error_q;

  logic [DataBits:0]   fifo_mem [FifoDepth];
  logic [PtrBits-1:0]  wr_ptr, rd_ptr;
  logic [CntBits-1:0]  fifo_used;
  logic [DataBits:0]   fifo_head;

  logic                beat, pop, issue, fire_done;
  logic [12:0]         bytes_to_4k;
  logic [CmpBits-1:0]  space, burst_min;

  // rid and rlast carry no information this block needs: a burst ends on
  // the beat count it requested.
  logic unused_ok;
  assign unused_ok = &{1'b0, mst_rid, mst_rlast};

  function automatic logic [PtrBits-1:0] ptr_inc(input logic [PtrBits-1:0] p);
    if (p == PtrBits'(FifoDepth - 1)) return '0;
    return p + PtrBits'(1);
  endfunction

  assign mst_arid    = 4'd0;
  assign mst_arsize  = 3'(SizeLog);
  assign mst_arburst = 2'b01;
  assign mst_arlock  = 2'b00;
  assign mst_arvalid = arvalid_q;
  assign mst_araddr  = araddr_q;
  assign mst_arlen   = arlen_q;
  assign done        = done_q;
  assign error       = error_q;

  // The head entry is presented combinationally from the registered fifo, so
  // a beat written on one edge is visible on dout the following cycle.
  assign fifo_head  = fifo_mem[rd_ptr];
  assign dout_valid = (fifo_used != '0);
  assign dout_data  = fifo_head[DataBits-1:0];
  assign dout_eof   = dout_valid & fifo_head[DataBits];
  assign pop        = dout_valid & dout_ready;

  // Words left before the next 4 KB boundary, and the burst size clamped to
  // the max burst, that boundary and the words still owed to the frame.
  always_comb begin
    bytes_to_4k = 13'h1000 - {1'b0, next_addr[11:0]};
    space       = CmpBits'(FifoDepth) - CmpBits'(fifo_used);
    burst_min   = CmpBits'(BurstSize);
    if (CmpBits'(until_4k) < burst_min) burst_min = CmpBits'(until_4k);
    if (CmpBits'(remain) < burst_min) burst_min = CmpBits'(remain);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= Idle;
    else        state <= state_d;
  end

  // Next-state logic and per-cycle strobes. IssueBurst always moves on in a
  // single cycle because the previous AR was accepted before its data came
  // back, so arvalid is already low by the time the next burst is prepared.
  always_comb begin
    state_d    = state;
    cfg_ready  = 1'b0;
    mst_rready = 1'b0;
    issue      = 1'b0;
    beat       = 1'b0;
    fire_done  = 1'b0;
    case (state)
      Idle: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_d = (cfg_len == '0) ? WaitDrain : Prep1;
      end
      Prep1:     state_d = Prep2;
      Prep2:     state_d = WaitSpace;
      WaitSpace: if (space >= CmpBits'(burst)) state_d = IssueBurst;
      IssueBurst: begin
        if (!arvalid_q || mst_arready) begin
          issue   = 1'b1;
          state_d = DoBurst;
        end
      end
      DoBurst: begin
        mst_rready = 1'b1;
        if (mst_rvalid) begin
          beat = 1'b1;
          if (burst == 5'd1) state_d = (remain == LenBits'(1)) ? WaitDrain : Prep1;
        end
      end
      WaitDrain: begin
        if (zero_frame || (pop && dout_eof)) begin
          fire_done = 1'b1;
          state_d   = Idle;
        end
      end
      default: state_d = Idle;
    endcase
  end

  // Frame bookkeeping, AR channel register and status outputs. zero_frame
  // remembers an empty frame, since remain also reaches zero after the
  // last beat of a normal frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      next_addr  <= '0;
      remain     <= '0;
      until_4k   <= '0;
      burst      <= '0;
      zero_frame <= 1'b0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 2'b00;
    end else begin
      done_q <= fire_done;
      if (state == Idle && cfg_valid) begin
        next_addr  <= cfg_addr;
        remain     <= cfg_len;
        zero_frame <= (cfg_len == '0);
      end
      if (state == Prep1) until_4k <= U4kBits'(bytes_to_4k >> SizeLog);
      if (state == Prep2) burst <= 5'(burst_min);
      if (issue) begin
        arvalid_q <= 1'b1;
        araddr_q  <= next_addr;
        arlen_q   <= 4'(burst - 5'd1);
        next_addr <= next_addr + (AddrBits'(burst) << SizeLog);
      end else if (arvalid_q && mst_arready) begin
        arvalid_q <= 1'b0;
      end
      if (beat) begin
        burst  <= burst - 5'd1;
        remain <= remain - LenBits'(1);
        if (mst_rresp != 2'b00) error_q <= mst_rresp;
      end
    end
  end

  // Fifo pointers and occupancy; each entry stores {eof, data}.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_used <= '0;
    end else begin
      if (beat) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({beat, pop})
        2'b10:   fifo_used <= fifo_used + CntBits'(1);
        2'b01:   fifo_used <= fifo_used - CntBits'(1);
        default: fifo_used <= fifo_used;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (beat) fifo_mem[wr_ptr] <= {(remain == LenBits'(1)), mst_rdata};
  end

endmodule

// File: tb/tb_dma_reader_len.sv
// tb_dma_reader_len
// Table-driven bench for dma_reader_len. A behavioural AXI read slave serves
// words from a synthetic memory (each word derived from its own address) and
// a monitor checks every output word, the AR requests and the done pulse.
module tb_dma_reader_len;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_addr = '0;
  logic [15:0] cfg_len = '0;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [63:0] dout_data;
  logic        dout_eof;
  logic        mst_arvalid;
  logic        mst_arready = 1'b0;
  logic [3:0]  mst_arid;
  logic [31:0] mst_araddr;
  logic [3:0]  mst_arlen;
  logic [2:0]  mst_arsize;
  logic [1:0]  mst_arburst;
  logic [1:0]  mst_arlock;
  logic        mst_rvalid = 1'b0;
  logic        mst_rready;
  logic [3:0]  mst_rid = 4'd0;
  logic [63:0] mst_rdata = '0;
  logic [1:0]  mst_rresp = 2'b00;
  logic        mst_rlast = 1'b0;
  logic        done;
  logic [1:0]  error;

  always #5 clk = ~clk;

  dma_reader_len #(
    .DataBits(64), .AddrBits(32), .LenBits(16), .BurstSize(16), .FifoDepth(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data), .dout_eof(dout_eof),
    .mst_arvalid(mst_arvalid), .mst_arready(mst_arready), .mst_arid(mst_arid),
    .mst_araddr(mst_araddr), .mst_arlen(mst_arlen), .mst_arsize(mst_arsize),
    .mst_arburst(mst_arburst), .mst_arlock(mst_arlock),
    .mst_rvalid(mst_rvalid), .mst_rready(mst_rready), .mst_rid(mst_rid),
    .mst_rdata(mst_rdata), .mst_rresp(mst_rresp), .mst_rlast(mst_rlast),
    .done(done), .error(error)
  );

  typedef struct {
    logic [31:0] addr;
    logic [15:0] len;
    int          hold;
    int          err_beat;
    int          exp_ars;
    logic [3:0]  exp_arlen0;
    logic [3:0]  exp_arlen1;
    logic [31:0] exp_addr1;
    logic [1:0]  exp_error;
  } vec_t;

  vec_t vecs[8];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Frame description written by the stimulus side, read by the monitor.
  logic [31:0] frame_addr = '0;
  int frame_len = 0;
  int hold_cycles = 0;
  int err_at = 0;
  int frame_start = 0;
  int frame_id = 0;
  int cfg_cyc = 0;

  // Monitor-owned per-frame observations.
  int seen_id = 0;
  int words_seen = 0;
  int ar_count = 0;
  int done_count = 0;
  int beats_total = 0;
  int beat_num = 0;
  int beats_left = 0;
  int first_arv_cyc = -1;
  int eof_cyc = 0;
  int done_cyc = 0;
  logic [31:0] r_addr = '0;
  logic [31:0] ar_addr_log[8];
  logic [3:0]  ar_len_log[8];
  int          ar_cyc_log[8];

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Slave and stream monitor. All decisions are made on the falling edge:
  // inputs chosen here and outputs read here together decide the handshakes
  // of the next rising edge. Every DUT output used is registered-state only.
  always @(negedge clk) begin
    if (frame_id != seen_id) begin
      seen_id       = frame_id;
      words_seen    = 0;
      ar_count      = 0;
      done_count    = 0;
      beats_total   = 0;
      beat_num      = 0;
      first_arv_cyc = -1;
    end
    mst_arready = (cyc % 3) != 0;
    if (!rst_n) begin
      beats_left = 0;
      mst_rvalid = 1'b0;
      mst_rresp  = 2'b00;
      mst_rlast  = 1'b0;
    end else begin
      dout_ready = (cyc - frame_start) >= hold_cycles;
      if (beats_left > 0) begin
        mst_rvalid = 1'b1;
        mst_rdata  = mem_word(r_addr);
        mst_rresp  = (beat_num + 1 == err_at) ? 2'b10 : 2'b00;
        mst_rlast  = (beats_left == 1);
        checkOutput("rready_in_burst", 64'(mst_rready), 64'd1);
        if (mst_rready) begin
          r_addr = r_addr + 32'd8;
          beats_left--;
          beat_num++;
          beats_total++;
        end
      end else begin
        mst_rvalid = 1'b0;
        mst_rresp  = 2'b00;
        mst_rlast  = 1'b0;
      end
      if (mst_arvalid && first_arv_cyc < 0) first_arv_cyc = cyc;
      if (mst_arvalid && mst_arready) begin
        checkOutput("one_outstanding", 64'(beats_left), 64'd0);
        checkOutput("ar_no_4k_cross", 64'((int'(mst_araddr[11:0]) + (int'(mst_arlen) + 1) * 8) <= 4096), 64'd1);
        checkOutput("ar_fifo_room", 64'((beats_total - words_seen + int'(mst_arlen) + 1) <= 32), 64'd1);
        if (ar_count < 8) begin
          ar_addr_log[ar_count] = mst_araddr;
          ar_len_log[ar_count]  = mst_arlen;
          ar_cyc_log[ar_count]  = cyc;
        end
        ar_count++;
        r_addr     = mst_araddr;
        beats_left = int'(mst_arlen) + 1;
      end
      if (dout_valid && dout_ready) begin
        checkOutput("dout_data", dout_data, mem_word(frame_addr + 32'(words_seen * 8)));
        checkOutput("dout_eof", 64'(dout_eof), 64'(words_seen == frame_len - 1));
        if (dout_eof) eof_cyc = cyc;
        words_seen++;
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
        checkOutput("cfg_ready_with_done", 64'(cfg_ready), 64'd1);
      end
    end
  end

  task automatic startFrame(input logic [31:0] addr, input logic [15:0] len, input int hold, input int err);
    int got;
    @(negedge clk);
    frame_addr  = addr;
    frame_len   = int'(len);
    hold_cycles = hold;
    err_at      = err;
    frame_start = cyc;
    frame_id++;
    cfg_addr  = addr;
    cfg_len   = len;
    cfg_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      if (cfg_ready) begin
        got     = 1;
        cfg_cyc = cyc;
      end
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    checkOutput("cfg_accepted", 64'(got), 64'd1);
  endtask

  // Runs one table entry to completion and checks its frame-level results.
  // Latencies are in falling-edge counts: a handshake seen at count c lands
  // on the next rising edge, so arvalid four cycles after the cfg edge shows
  // up at c+5, and done the cycle after the eof edge at c+1.
  task automatic applyStimulus(input vec_t v);
    int n;
    startFrame(v.addr, v.len, v.hold, v.err_beat);
    n = 0;
    while (done_count == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checkOutput("words", 64'(words_seen), 64'(v.len));
    checkOutput("done_pulses", 64'(done_count), 64'd1);
    checkOutput("ar_count", 64'(ar_count), 64'(v.exp_ars));
    checkOutput("error", 64'(error), 64'(v.exp_error));
    checkOutput("cfg_ready_idle", 64'(cfg_ready), 64'd1);
    if (v.exp_ars > 0 && ar_count > 0) begin
      checkOutput("ar0_addr", 64'(ar_addr_log[0]), 64'(v.addr));
      checkOutput("ar0_len", 64'(ar_len_log[0]), 64'(v.exp_arlen0));
      checkOutput("first_ar_latency", 64'(first_arv_cyc - cfg_cyc), 64'd5);
      checkOutput("done_latency", 64'(done_cyc - eof_cyc), 64'd1);
    end
    if (v.exp_ars == 0) begin
      checkOutput("zero_done_latency", 64'(done_cyc - cfg_cyc), 64'd2);
    end
    if (v.exp_ars > 1 && ar_count > 1) begin
      checkOutput("ar1_addr", 64'(ar_addr_log[1]), 64'(v.exp_addr1));
      checkOutput("ar1_len", 64'(ar_len_log[1]), 64'(v.exp_arlen1));
    end
    if (v.hold > 0 && ar_count > 2) begin
      checkOutput("ar2_withheld", 64'((ar_cyc_log[2] - frame_start) >= v.hold), 64'd1);
      checkOutput("ar2_len", 64'(ar_len_log[2]), 64'd7);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_arvalid"}, 64'(mst_arvalid), 64'd0);
    checkOutput({tag, "_rready"}, 64'(mst_rready), 64'd0);
    checkOutput({tag, "_dout_valid"}, 64'(dout_valid), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_error"}, 64'(error), 64'd0);
    checkOutput({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd1);
  endtask

  initial begin
    vec_t rst_vec;
    int n;
    // addr, len, hold, err_beat, ars, arlen0, arlen1, addr1, error
    vecs[0] = '{32'h0000_1000, 16'd16, 0,   0, 1, 4'd15, 4'd0,  32'h0,         2'b00};
    vecs[1] = '{32'h0000_0FE0, 16'd10, 0,   0, 2, 4'd3,  4'd5,  32'h0000_1000, 2'b00};
    vecs[2] = '{32'h0000_2000, 16'd40, 100, 0, 3, 4'd15, 4'd15, 32'h0000_2080, 2'b00};
    vecs[3] = '{32'h0000_5000, 16'd0,  0,   0, 0, 4'd0,  4'd0,  32'h0,         2'b00};
    vecs[4] = '{32'h0000_1FF8, 16'd2,  0,   0, 2, 4'd0,  4'd0,  32'h0000_2000, 2'b00};
    vecs[5] = '{32'hFFFF_FFF8, 16'd2,  0,   0, 2, 4'd0,  4'd0,  32'h0000_0000, 2'b00};
    vecs[6] = '{32'h0000_3008, 16'd3,  0,   2, 1, 4'd2,  4'd0,  32'h0,         2'b10};
    vecs[7] = '{32'h0000_6000, 16'd1,  0,   0, 1, 4'd0,  4'd0,  32'h0,         2'b10};

    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    checkOutput("arsize", 64'(mst_arsize), 64'd3);
    checkOutput("arburst", 64'(mst_arburst), 64'd1);
    checkOutput("arid", 64'(mst_arid), 64'd0);
    checkOutput("arlock", 64'(mst_arlock), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Reset in the middle of a burst, then a fresh 4-word frame. The sticky
    // error from the earlier frame must also be cleared by the reset.
    startFrame(32'h0000_4000, 16'd40, 0, 0);
    n = 0;
    while (beat_num < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mid_burst_reached", 64'(beat_num >= 5), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkResetState("midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    rst_vec = '{32'h0000_7000, 16'd4, 0, 0, 1, 4'd3, 4'd0, 32'h0, 2'b00};
    applyStimulus(rst_vec);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
